// File: rtl/pixel_buffer_ctrl_pkg.sv
// Shared definitions for pixel_buffer_ctrl and pixel_buffer:
// controller state encoding, address-width helper and line-buffer depth.
package pixel_buffer_ctrl_pkg;

  // Controller states; also exported on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Address width for a counter that spans 0..n-1 (never narrower than 1 bit).
  function automatic int log2_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Line-buffer depth: the window registers hold FILTER_SIZE-1 of each row,
  // so the line buffer only needs to delay the remainder.
  function automatic int depth_f(input int image_size, input int filter_size);
    return image_size - (filter_size - 1);
  endfunction

endpackage

// File: rtl/pixel_buffer_ctrl_wrap.sv
// wrap_counter: modulo-(MAX+1) counter with a combinational wrap flag that
// is high on the increment that takes the count from MAX back to 0.
module wrap_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] count_d, count_q;

  assign wrap  = inc && (count_q == WIDTH'(MAX));
  assign count = count_q;

  // Next count: advance on inc, fold back to zero at MAX.
  always_comb begin
    count_d = count_q;
    if (inc) count_d = wrap ? '0 : count_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/pixel_buffer_ctrl.sv
// pixel_buffer_ctrl: drives pixel_buffer from a valid/ready pixel stream and
// flags complete in-image FILTER_SIZE x FILTER_SIZE windows.
// Optional macro PIXEL_BUFFER_CTRL_WIN_COORD_EN adds win_row/win_col, the
// top-left coordinate of the flagged window.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Pixel side: in_ready depends on win_valid/win_ready but never on in_valid.
// Window side: win_valid stays high with stable buffer contents until a
// cycle with win_ready; a new pixel may be accepted in that same cycle.
module pixel_buffer_ctrl
  import pixel_buffer_ctrl_pkg::*;
#(
  parameter int  FILTER_SIZE = 3,
  parameter int  IMAGE_SIZE  = 28,
  parameter int  D_WIDTH     = 8,
  localparam int AW          = log2_f(IMAGE_SIZE)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] in_data,
  output logic               buf_clk_en,
  output logic [AW-1:0]      buf_wr_addr,
  output logic [AW-1:0]      buf_rd_addr,
  output logic [D_WIDTH-1:0] buf_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic               frame_done,
`ifdef PIXEL_BUFFER_CTRL_WIN_COORD_EN
  output logic [AW-1:0]      win_row,
  output logic [AW-1:0]      win_col,
`endif
  output state_e             dbg_state
);

  localparam int DEPTH = depth_f(IMAGE_SIZE, FILTER_SIZE);

  state_e        state_d, state_q;
  logic          win_valid_d, win_valid_q;
  logic          accept, win_hit;
  logic [AW-1:0] ptr, col, row;
  logic          col_wrap, row_wrap, ptr_wrap_unused;

  assign in_ready   = ((state_q == ST_FILL) || (state_q == ST_RUN)) &&
                      (!win_valid_q || win_ready);
  assign accept     = in_valid && in_ready;
  assign buf_clk_en = accept;
  assign buf_data   = in_data;
  // Same address for read and write: the old entry is read out as the new
  // one is written, giving a DEPTH-accept delay through the line buffer.
  assign buf_wr_addr = ptr;
  assign buf_rd_addr = ptr;
  assign win_valid   = win_valid_q;
  assign frame_done  = (state_q == ST_DONE);
  assign dbg_state   = state_q;

  // The accepted pixel completes a window only when a full window fits above
  // and to the left of it inside the image.
  assign win_hit = accept && (row >= AW'(FILTER_SIZE - 1)) &&
                   (col >= AW'(FILTER_SIZE - 1));

  // Line-buffer pointer; deliberately carried across frames.
  wrap_counter #(.WIDTH(AW), .MAX(DEPTH - 1)) u_ptr (
    .clk(clk), .rst_n(rst_n), .inc(accept), .count(ptr), .wrap(ptr_wrap_unused)
  );

  // Column position of the next pixel.
  wrap_counter #(.WIDTH(AW), .MAX(IMAGE_SIZE - 1)) u_col (
    .clk(clk), .rst_n(rst_n), .inc(accept), .count(col), .wrap(col_wrap)
  );

  // Row position; row_wrap marks acceptance of the frame's last pixel.
  wrap_counter #(.WIDTH(AW), .MAX(IMAGE_SIZE - 1)) u_row (
    .clk(clk), .rst_n(rst_n), .inc(col_wrap), .count(row), .wrap(row_wrap)
  );

  // Frame sequencing and window-valid next state.
  always_comb begin
    state_d     = state_q;
    win_valid_d = win_valid_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FILL;
      ST_FILL: if (col_wrap && (row == AW'(FILTER_SIZE - 2))) state_d = ST_RUN;
      ST_RUN:  if (row_wrap) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (win_hit)        win_valid_d = 1'b1;
    else if (win_ready) win_valid_d = 1'b0;
  end

  // State and window-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
    end
  end

`ifdef PIXEL_BUFFER_CTRL_WIN_COORD_EN
  logic [AW-1:0] win_row_d, win_row_q, win_col_d, win_col_q;

  assign win_row = win_row_q;
  assign win_col = win_col_q;

  // Capture the top-left corner of each newly flagged window; hold otherwise.
  always_comb begin
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    if (win_hit) begin
      win_row_d = row - AW'(FILTER_SIZE - 1);
      win_col_d = col - AW'(FILTER_SIZE - 1);
    end
  end

  // Window coordinate registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_buffer_ctrl.sv
// Testbench for pixel_buffer_ctrl at IMAGE_SIZE=5, FILTER_SIZE=3, D_WIDTH=8.
// A behavioural pixel_buffer model is fed from the DUT's buffer-side outputs;
// expected windows come from the frame pixel grid by position arithmetic.
module tb_pixel_buffer_ctrl;
  import pixel_buffer_ctrl_pkg::*;

  localparam int IMG = 5, FLT = 3, DW = 8, AW = 3, DEPTH = 3, NPIX = IMG * IMG;
  localparam int WW = 9 * DW;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, in_ready, buf_clk_en, win_valid, win_ready, frame_done;
  logic [DW-1:0] in_data, buf_data;
  logic [AW-1:0] buf_wr_addr, buf_rd_addr;
  state_e dbg_state;
`ifdef PIXEL_BUFFER_CTRL_WIN_COORD_EN
  logic [AW-1:0] win_row, win_col;
`endif

  always #5 clk = ~clk;

  pixel_buffer_ctrl #(.FILTER_SIZE(FLT), .IMAGE_SIZE(IMG), .D_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .buf_clk_en(buf_clk_en), .buf_wr_addr(buf_wr_addr),
    .buf_rd_addr(buf_rd_addr), .buf_data(buf_data), .win_valid(win_valid),
    .win_ready(win_ready), .frame_done(frame_done),
`ifdef PIXEL_BUFFER_CTRL_WIN_COORD_EN
    .win_row(win_row), .win_col(win_col),
`endif
    .dbg_state(dbg_state)
  );

  // Scoreboard and reference state
  logic [WW-1:0]   exp_q[$];
  logic [2*AW-1:0] coord_q[$];
  int phase;      // 0 idle, 1 frame active, 2 done cycle
  int acc_cnt, exp_ptr, base;
  int errors = 0, checks = 0;
  int win_seen, first_acc;
  bit first_seen;
  logic [WW-1:0] first_win;
  // Behavioural pixel_buffer
  logic [DW-1:0] lb[2][DEPTH];
  logic [DW-1:0] mw[3][3];
  // Values captured just before the active edge
  logic cap_start, cap_valid, cap_wr, cap_er, cap_en;
  logic [AW-1:0] cap_waddr, cap_raddr;
  logic [DW-1:0] cap_data;

  typedef struct {
    logic s, v, wr;
    logic exp_rdy, exp_en;
    int   exp_addr;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_win(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_in_ready();
    return (phase == 1) && ((exp_q.size() == 0) || win_ready);
  endfunction

  // Window as seen in the model buffer; row 0 is the top (oldest) image row.
  function automatic logic [WW-1:0] model_win();
    logic [WW-1:0] r;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) r[(i*3+j)*DW +: DW] = mw[2-i][j];
    return r;
  endfunction

  // Expected window with top-left (tr,tc): element j runs right-to-left.
  function automatic logic [WW-1:0] ref_win(input int b, input int tr, input int tc);
    logic [WW-1:0] r;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) r[(i*3+j)*DW +: DW] = DW'(b + (tr + i) * IMG + tc + 2 - j);
    return r;
  endfunction

  task automatic drive(input logic s, input logic v, input logic wr);
    @(negedge clk);
    start     = s;
    in_valid  = v;
    in_data   = v ? DW'(base + acc_cnt) : DW'($urandom);
    win_ready = wr;
    #1;
  endtask

  task automatic check_outputs();
    logic er, ea;
    er = exp_in_ready();
    ea = in_valid && er;
    chk("in_ready", in_ready, er);
    chk("buf_clk_en", buf_clk_en, ea);
    if (ea) chk("buf_data", buf_data, in_data);
    chk("buf_wr_addr", buf_wr_addr, exp_ptr);
    chk("buf_rd_addr", buf_rd_addr, exp_ptr);
    chk("win_valid", win_valid, exp_q.size() != 0);
    chk("frame_done", frame_done, phase == 2);
    if (exp_q.size() != 0) begin
      chk_win("window", model_win(), exp_q[0]);
`ifdef PIXEL_BUFFER_CTRL_WIN_COORD_EN
      chk("win_row", win_row, coord_q[0][2*AW-1:AW]);
      chk("win_col", win_col, coord_q[0][AW-1:0]);
`endif
    end
    if (win_valid && !first_seen) begin
      first_seen = 1;
      first_acc  = acc_cnt;
      first_win  = model_win();
    end
    if (win_valid && win_ready) win_seen++;
  endtask

  task automatic finish_cycle();
    logic [DW-1:0] rd0, rd1;
    int r, c;
    cap_start = start; cap_valid = in_valid; cap_wr = win_ready; cap_er = exp_in_ready();
    cap_en = buf_clk_en; cap_waddr = buf_wr_addr; cap_raddr = buf_rd_addr; cap_data = buf_data;
    @(posedge clk);
    if (!rst_n) return;
    // pixel_buffer model: read-before-write line buffers feeding shift rows
    if (cap_en) begin
      rd0 = lb[0][int'(cap_raddr) % DEPTH];
      rd1 = lb[1][int'(cap_raddr) % DEPTH];
      lb[0][int'(cap_waddr) % DEPTH] = mw[0][1];
      lb[1][int'(cap_waddr) % DEPTH] = mw[1][1];
      for (int i = 0; i < 3; i++) begin
        mw[i][2] = mw[i][1];
        mw[i][1] = mw[i][0];
      end
      mw[0][0] = cap_data; mw[1][0] = rd0; mw[2][0] = rd1;
    end
    // reference: consumption, then acceptance, then frame phase
    if (exp_q.size() != 0 && cap_wr) begin
      void'(exp_q.pop_front());
      void'(coord_q.pop_front());
    end
    if (phase == 2) phase = 0;
    else if (phase == 0) begin
      if (cap_start) begin phase = 1; acc_cnt = 0; end
    end else if (cap_valid && cap_er) begin
      r = acc_cnt / IMG;
      c = acc_cnt % IMG;
      if (r >= FLT - 1 && c >= FLT - 1) begin
        exp_q.push_back(ref_win(base, r - (FLT - 1), c - (FLT - 1)));
        coord_q.push_back({AW'(r - (FLT - 1)), AW'(c - (FLT - 1))});
      end
      acc_cnt++;
      exp_ptr = (exp_ptr + 1) % DEPTH;
      if (acc_cnt == NPIX) phase = 2;
    end
  endtask

  task automatic step(input logic s, input logic v, input logic wr);
    drive(s, v, wr);
    check_outputs();
    finish_cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; in_valid = 0; win_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_wr_addr", buf_wr_addr, 0);
    chk("rst_rd_addr", buf_rd_addr, 0);
    chk("rst_state", int'(dbg_state), int'(ST_IDLE));
`ifdef PIXEL_BUFFER_CTRL_WIN_COORD_EN
    chk("rst_win_row", win_row, 0);
    chk("rst_win_col", win_col, 0);
`endif
    phase = 0; acc_cnt = 0; exp_ptr = 0;
    exp_q.delete(); coord_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // mode 0: always ready; 1: stall 4 cycles on the first window; 2: random ready
  task automatic continue_frame(input int mode, input bit gaps);
    int cyc, stall_left;
    bit stalled;
    logic v, wr;
    cyc = 0; stall_left = 0; stalled = 0;
    while ((phase != 0 || exp_q.size() != 0) && cyc < 400) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mode == 1 && !stalled && exp_q.size() != 0) begin stalled = 1; stall_left = 4; end
      if (mode == 2) wr = 1'($urandom_range(0, 1));
      else           wr = (stall_left == 0);
      if (phase == 0) wr = 1'b1;
      step(1'b0, v, wr);
      if (stall_left > 0) stall_left--;
      cyc++;
    end
    chk("frame_timeout", cyc < 400, 1);
    chk("window_count", win_seen, (IMG - FLT + 1) * (IMG - FLT + 1));
  endtask

  task automatic new_frame(input int b);
    base = b; win_seen = 0; first_seen = 0;
    step(1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic [WW-1:0] w100;
    vecs[0] = '{s:0, v:1, wr:1, exp_rdy:0, exp_en:0, exp_addr:0};
    vecs[1] = '{s:1, v:0, wr:1, exp_rdy:0, exp_en:0, exp_addr:0};
    vecs[2] = '{s:0, v:1, wr:1, exp_rdy:1, exp_en:1, exp_addr:0};
    vecs[3] = '{s:0, v:1, wr:1, exp_rdy:1, exp_en:1, exp_addr:1};
    vecs[4] = '{s:0, v:0, wr:1, exp_rdy:1, exp_en:0, exp_addr:2};
    vecs[5] = '{s:0, v:1, wr:1, exp_rdy:1, exp_en:1, exp_addr:2};
    vecs[6] = '{s:0, v:1, wr:1, exp_rdy:1, exp_en:1, exp_addr:0};
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++) lb[i][j] = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) mw[i][j] = '0;
    rst_n = 1; start = 0; in_valid = 0; in_data = '0; win_ready = 0;
    phase = 0; acc_cnt = 0; exp_ptr = 0; base = 0; win_seen = 0; first_seen = 0;
    first_acc = 0; first_win = '0;

    // Frame A: pixels 0..24, always consumed; opened by the vector table
    do_reset();
    for (int k = 0; k < 7; k++) begin
      drive(vecs[k].s, vecs[k].v, vecs[k].wr);
      chk("vec_in_ready", in_ready, vecs[k].exp_rdy);
      chk("vec_clk_en", buf_clk_en, vecs[k].exp_en);
      chk("vec_addr", buf_wr_addr, vecs[k].exp_addr);
      check_outputs();
      finish_cycle();
    end
    continue_frame(0, 0);
    chk("first_win_latency", first_acc, 13);
    chk_win("first_win_A", first_win, ref_win(0, 0, 0));

    // Frame B: backpressure on the first window
    new_frame(50);
    continue_frame(1, 0);
    // Frame C: source gaps and random consumption
    new_frame(150);
    continue_frame(2, 1);

    // Frame D: interrupted at pixel 8, with a stray start mid-frame
    new_frame(60);
    for (int k = 0; k < 9; k++) step(k == 4, 1'b1, 1'b1);
    chk("mid_acc_cnt", acc_cnt, 9);
    do_reset();
    new_frame(100);
    continue_frame(0, 0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) w100[(i*3+j)*DW +: DW] = DW'(100 + i * 5 + (2 - j));
    chk_win("first_win_after_reset", first_win, w100);

    // Frame E: gaps with full consumption
    new_frame(30);
    continue_frame(0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
